add8_err_monitor: RTL and testbench
===================================

Name: add8_err_monitor

Overview:
- On-chip error characteriser for 8-bit approximate adders: the consuming end of the adder's A/B→O interface.
- Drives every (A,B) operand pair into an attached combinational approximate adder and reads back its 9-bit sum.
- Compares each readback against the exact sum and accumulates error-count, mean-error, worst-case-error and Hamming-distance metrics.
- Used in silicon and FPGA bring-up to confirm a library adder's published error figures.

Parameters:
- WIDTH, 8, operand width; sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 0, extra wait cycles per vector before sampling the DUT sum (0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep.
- a_out  out  WIDTH  operand A to the DUT.
- b_out  out  WIDTH  operand B to the DUT.
- dut_sum  in  WIDTH+1  DUT result O, combinational from a_out/b_out.
- busy  out  1  sweep in progress.
- done  out  1  metrics valid; held until the next start.
- err_cnt  out  2*WIDTH+1  number of vectors with dut_sum ≠ exact.
- abs_err_sum  out  3*WIDTH+1  Σ|dut_sum − exact|.
- wce  out  WIDTH+1  max |dut_sum − exact|.
- hd_sum  out  2*WIDTH+4  Σ popcount(dut_sum XOR exact).

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; vector index 0; settle counter 0.
- Vector index idx has 2*WIDTH bits; a_out = idx[2W-1:W], b_out = idx[W-1:0]. Both are registered outputs.
- exact = a_out + b_out, zero-extended to WIDTH+1 bits.
- error = |dut_sum − exact|, computed in WIDTH+2-bit signed arithmetic, then magnitude.
- FSM states:
  - IDLE: busy=0. If start=1: clear all four metrics and done, set idx=0 and settle counter=0, go to RUN.
  - RUN: busy=1.
    - Settle counter counts 0..SETTLE.
    - On the edge where the counter equals SETTLE, capture dut_sum and exact into a compare stage, reset the counter, and increment idx.
    - If idx was all-ones at that capture, go to FLUSH instead; idx wraps to 0.
  - FLUSH: busy=1. The compare stage updates the accumulators for the last vector. Next state DONE with done=1.
  - DONE: busy=0, done=1, metrics and a_out/b_out frozen. start=1 behaves as in IDLE and also clears done on that edge.
- Compare stage: one-cycle pipeline. Accumulators update on the edge after capture:
  - err_cnt += (error≠0)
  - abs_err_sum += error
  - wce = max(wce, error)
  - hd_sum += popcount
  - The compare-valid flag is cleared in IDLE, DONE and on start.
- Timing: count the edge sampling start as edge 0. Vector i is sampled at edge (i+1)(SETTLE+1). done rises at edge 2^(2W)(SETTLE+1)+1. busy falls at that same edge.
- start while busy=1 is ignored.
- Accumulator widths are sized so overflow is impossible for a full sweep. No saturation logic.
- Reset mid-sweep aborts immediately: all metrics 0, done=0, outputs per the reset values above.
- X on dut_sum is not filtered; the DUT must be driven only from a_out/b_out.

Test Plan:
1. DUT = exact adder (dut_sum=a+b), SETTLE=0, start pulse → done at edge 65537; err_cnt=0, abs_err_sum=0, wce=0, hd_sum=0; busy high for edges 1..65536.
2. DUT stub dut_sum=(a+b)|1 → err_cnt=32768, abs_err_sum=32768, wce=1, hd_sum=32768.
3. DUT stub dut_sum=0 → err_cnt=65535, abs_err_sum=16711680, wce=510.
4. SETTLE=2 with a one-cycle-delayed exact-adder stub → err_cnt=0 and done at edge 196609. Same stub with SETTLE=0 → err_cnt>0.
5. Assert rst_n=0 at idx=1000 mid-sweep → all outputs 0 asynchronously. After release, start → full sweep produces the scenario-1 results.
6. start pulses at edges 5 and 40000 during a sweep → ignored, done timing unchanged. start while DONE → done drops at that edge, metrics cleared, new sweep reproduces the identical results.

Source files
------------

// File: rtl/add8_err_monitor.sv
// add8_err_monitor: on-chip error characteriser for WIDTH-bit approximate adders.
// Sweeps every (A,B) operand pair into an attached combinational adder.
// Compares each readback against the exact sum and accumulates the error
// count, the summed absolute error, the worst-case error and the summed
// Hamming distance.
module add8_err_monitor #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH:0]       dut_sum,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [3*WIDTH:0]     abs_err_sum,
    output logic [WIDTH:0]       wce,
    output logic [2*WIDTH+3:0]   hd_sum
);

    localparam int IW = 2 * WIDTH;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of set bits in a (WIDTH+1)-bit word, sized to the Hamming accumulator.
    function automatic logic [2*WIDTH+3:0] popcount(input logic [WIDTH:0] v);
        logic [2*WIDTH+3:0] pc;
        pc = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            pc = pc + (2*WIDTH+4)'(v[i]);
        end
        return pc;
    endfunction

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WIDTH:0]       cmp_sum_q, cmp_sum_d;
    logic [WIDTH:0]       cmp_exact_q, cmp_exact_d;
    logic                 cmp_vld_q, cmp_vld_d;
    logic [2*WIDTH:0]     err_cnt_q, err_cnt_d;
    logic [3*WIDTH:0]     abs_q, abs_d;
    logic [WIDTH:0]       wce_q, wce_d;
    logic [2*WIDTH+3:0]   hd_q, hd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]         exact_s;
    logic signed [WIDTH+1:0] diff_s;
    logic [WIDTH+1:0]       mag_s;
    logic [WIDTH:0]         err_s;

    // Exact reference sum and the error magnitude of the captured vector.
    always_comb begin
        exact_s = {1'b0, idx_q[IW-1:WIDTH]} + {1'b0, idx_q[WIDTH-1:0]};
        diff_s  = $signed({1'b0, cmp_sum_q}) - $signed({1'b0, cmp_exact_q});
        if (diff_s[WIDTH+1]) begin
            mag_s = -diff_s;
        end else begin
            mag_s = diff_s;
        end
        err_s = mag_s[WIDTH:0];
    end

    // Sweep sequencing, capture stage and metric accumulation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cmp_sum_d   = cmp_sum_q;
        cmp_exact_d = cmp_exact_q;
        cmp_vld_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        abs_d       = abs_q;
        wce_d       = wce_q;
        hd_d        = hd_q;
        busy_d      = busy_q;
        done_d      = done_q;

        // The compare stage retires one captured vector per valid cycle.
        if (cmp_vld_q) begin
            err_cnt_d = err_cnt_q + (2*WIDTH+1)'(err_s != '0);
            abs_d     = abs_q + (3*WIDTH+1)'(err_s);
            hd_d      = hd_q + popcount(cmp_sum_q ^ cmp_exact_q);
            if (err_s > wce_q) begin
                wce_d = err_s;
            end else begin
                wce_d = wce_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    err_cnt_d = '0;
                    abs_d     = '0;
                    wce_d     = '0;
                    hd_d      = '0;
                    done_d    = 1'b0;
                    idx_d     = '0;
                    cnt_d     = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (cnt_q == SETTLE_C) begin
                    cmp_sum_d   = dut_sum;
                    cmp_exact_d = exact_s;
                    cmp_vld_d   = 1'b1;
                    cnt_d       = 4'd0;
                    idx_d       = idx_q + IW'(1);
                    if (idx_q == {IW{1'b1}}) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= 4'd0;
            cmp_sum_q   <= '0;
            cmp_exact_q <= '0;
            cmp_vld_q   <= 1'b0;
            err_cnt_q   <= '0;
            abs_q       <= '0;
            wce_q       <= '0;
            hd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cmp_sum_q   <= cmp_sum_d;
            cmp_exact_q <= cmp_exact_d;
            cmp_vld_q   <= cmp_vld_d;
            err_cnt_q   <= err_cnt_d;
            abs_q       <= abs_d;
            wce_q       <= wce_d;
            hd_q        <= hd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_out       = idx_q[IW-1:WIDTH];
    assign b_out       = idx_q[WIDTH-1:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cnt     = err_cnt_q;
    assign abs_err_sum = abs_q;
    assign wce         = wce_q;
    assign hd_sum      = hd_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor, run at WIDTH=4 (256-vector sweeps).
// Expected figures for W=4: even sums 128 of 256; sum of all a+b = 3840;
// max exact sum 30; done at edge 256*(SETTLE+1)+1.
module tb_add8_err_monitor;

    localparam int W  = 4;
    localparam int NV = 1 << (2 * W);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, start2;
    logic [1:0]       mode;
    logic [W-1:0]     a_out, b_out, a2, b2;
    logic [W:0]       dut_sum, dut_sum2, dly_q, dly2_q;
    logic             busy, done, busy2, done2;
    logic [2*W:0]     err_cnt, err_cnt2;
    logic [3*W:0]     abs_err_sum, abs_err_sum2;
    logic [W:0]       wce, wce2;
    logic [2*W+3:0]   hd_sum, hd_sum2;

    int n_asserts = 0;
    int n_fail    = 0;
    int hd_zero_exp;

    add8_err_monitor #(.WIDTH(W), .SETTLE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
        .dut_sum(dut_sum), .busy(busy), .done(done), .err_cnt(err_cnt),
        .abs_err_sum(abs_err_sum), .wce(wce), .hd_sum(hd_sum)
    );

    add8_err_monitor #(.WIDTH(W), .SETTLE(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
        .dut_sum(dut_sum2), .busy(busy2), .done(done2), .err_cnt(err_cnt2),
        .abs_err_sum(abs_err_sum2), .wce(wce2), .hd_sum(hd_sum2)
    );

    always #5 clk = ~clk;

    // One-cycle-delayed exact adder stubs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q  <= '0;
            dly2_q <= '0;
        end else begin
            dly_q  <= {1'b0, a_out} + {1'b0, b_out};
            dly2_q <= {1'b0, a2} + {1'b0, b2};
        end
    end

    // Adder stub selected by mode.
    always_comb begin
        case (mode)
            2'd0:    dut_sum = {1'b0, a_out} + {1'b0, b_out};
            2'd1:    dut_sum = ({1'b0, a_out} + {1'b0, b_out}) | 5'd1;
            2'd2:    dut_sum = 5'd0;
            2'd3:    dut_sum = dly_q;
            default: dut_sum = {1'b0, a_out} + {1'b0, b_out};
        endcase
    end
    assign dut_sum2 = dly2_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_metrics(input string tag, input int e_cnt, input int e_abs,
                               input int e_wce, input int e_hd);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(e_cnt));
        chk({tag, "_abs"},     64'(abs_err_sum), 64'(e_abs));
        chk({tag, "_wce"},     64'(wce), 64'(e_wce));
        chk({tag, "_hd"},      64'(hd_sum), 64'(e_hd));
    endtask

    // Pulse start, count edges to done, check the busy window; p1/p2 are extra
    // start pulses (edge numbers) issued during the sweep; clr checks edge-0 clearing.
    task automatic sweep(input int which, input int exp_edge, input int p1, input int p2,
                         input bit clr);
        int n;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
        if (clr) begin
            chk("restart_done_low", 64'(done), 64'd0);
            chk("restart_cnt_clr",  64'(err_cnt), 64'd0);
            chk("restart_hd_clr",   64'(hd_sum), 64'd0);
        end
        n       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < exp_edge + 50) begin
            start = ((n + 1) == p1 || (n + 1) == p2) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            n++;
            if ((which == 0) ? done : done2) seen = 1'b1;
            else if (!((which == 0) ? busy : busy2)) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk("done_edge", seen ? 64'(n) : 64'hFFFF_FFFF, 64'(exp_edge));
        chk("busy_window", 64'(busy_ok), 64'd1);
        chk("busy_low_at_done", (which == 0) ? 64'(busy) : 64'(busy2), 64'd0);
    endtask

    initial begin
        int guard;
        hd_zero_exp = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                hd_zero_exp += $countones(a + b);
            end
        end

        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_a", 64'(a_out), 64'd0);
        chk_metrics("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: exact adder
        mode = 2'd0;
        sweep(0, NV + 1, -1, -1, 1'b0);
        chk_metrics("exact", 0, 0, 0, 0);

        // 2: LSB forced high
        mode = 2'd1;
        sweep(0, NV + 1, -1, -1, 1'b0);
        chk_metrics("or1", 128, 128, 1, 128);

        // 3: constant zero
        mode = 2'd2;
        sweep(0, NV + 1, -1, -1, 1'b0);
        chk_metrics("zero", 255, 3840, 30, hd_zero_exp);

        // 4: delayed adder with SETTLE=2, then with SETTLE=0
        sweep(1, 3 * NV + 1, -1, -1, 1'b0);
        chk("s2_err_cnt", 64'(err_cnt2), 64'd0);
        chk("s2_abs", 64'(abs_err_sum2), 64'd0);
        chk("s2_wce", 64'(wce2), 64'd0);
        chk("s2_hd", 64'(hd_sum2), 64'd0);
        mode = 2'd3;
        sweep(0, NV + 1, -1, -1, 1'b0);
        chk("s0_delay_err_nonzero", 64'(err_cnt != '0), 64'd1);

        // 5: reset mid-sweep at idx=100
        mode = 2'd1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while ({a_out, b_out} != 8'd100 && guard < 2 * NV) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_idx100", 64'({a_out, b_out}), 64'd100);
        chk("pre_reset_cnt_nonzero", 64'(err_cnt != '0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_a", 64'(a_out), 64'd0);
        chk("arst_b", 64'(b_out), 64'd0);
        chk_metrics("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 2'd0;
        sweep(0, NV + 1, -1, -1, 1'b0);
        chk_metrics("post_rst", 0, 0, 0, 0);

        // 6: ignored starts during sweep, then restart from DONE
        mode = 2'd1;
        sweep(0, NV + 1, 5, 200, 1'b0);
        chk_metrics("ign_start", 128, 128, 1, 128);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 64'(done), 64'd1);
        sweep(0, NV + 1, -1, -1, 1'b1);
        chk_metrics("restart", 128, 128, 1, 128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
